// File: rtl/wb_select_pkg.sv
// wb_select_pkg: shared definitions for the write-back select block.
//   - ext_mode encodings for load extension (codes 5..7 are reserved and behave as word)
//   - the four constant write-back values
//   - select offsets of the non-source entries, relative to NUM_SRC
package wb_select_pkg;

  typedef enum logic [2:0] {
    ExtWord  = 3'd0,
    ExtByteS = 3'd1,
    ExtByteU = 3'd2,
    ExtHalfS = 3'd3,
    ExtHalfU = 3'd4
  } ext_mode_e;

  localparam int unsigned ConstA = 227;
  localparam int unsigned ConstB = 1;
  localparam int unsigned ConstC = 2;
  localparam int unsigned ConstD = 3;

  localparam int unsigned OffLoad   = 0;
  localparam int unsigned OffConstA = 1;
  localparam int unsigned OffConstB = 2;
  localparam int unsigned OffConstC = 3;
  localparam int unsigned OffConstD = 4;
  // Number of select codes mapped above the general sources.
  localparam int unsigned NumExtra  = 5;

endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: combinational load-data extraction and extension.
//   mem_word_i  raw memory word
//   ext_mode_i  extension mode (see wb_select_pkg::ext_mode_e; reserved codes act as word)
//   byte_off_i  byte offset in the word; bit 0 is ignored for halfword loads
//   ext_data_o  extended value, DATA_W bits
module wb_load_ext
  import wb_select_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] mem_word_i,
  input  logic [2:0]        ext_mode_i,
  input  logic [1:0]        byte_off_i,
  output logic [DATA_W-1:0] ext_data_o
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = mem_word_i[7:0];
    unique case (byte_off_i)
      2'd0: byte_val = mem_word_i[7:0];
      2'd1: byte_val = mem_word_i[15:8];
      2'd2: byte_val = mem_word_i[23:16];
      2'd3: byte_val = mem_word_i[31:24];
      default: byte_val = mem_word_i[7:0];
    endcase
    half_val = byte_off_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
  end

  always_comb begin
    ext_data_o = mem_word_i;
    case (ext_mode_i)
      ExtByteS: ext_data_o = {{(DATA_W-8){byte_val[7]}}, byte_val};
      ExtByteU: ext_data_o = {{(DATA_W-8){1'b0}}, byte_val};
      ExtHalfS: ext_data_o = {{(DATA_W-16){half_val[15]}}, half_val};
      ExtHalfU: ext_data_o = {{(DATA_W-16){1'b0}}, half_val};
      default:  ext_data_o = mem_word_i;
    endcase
  end

endmodule

// File: rtl/wb_select.sv
// wb_select: write-back source select with one-cycle registered output and
// valid/ready handshakes on both sides.
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (sel, src_data, mem_word, ext_mode, byte_off)
//   out_valid/out_ready  result handshake on wb_data
//   sel_err              one-cycle pulse after an accepted request with an unmapped sel
// Build option: define WB_SELECT_SKID_EN to add a one-entry skid register; in_ready then
// comes straight from a flop (skid entry empty) instead of depending on out_ready.
module wb_select
  import wb_select_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned SEL_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [DATA_W-1:0]         mem_word,
  input  logic [2:0]                ext_mode,
  input  logic [1:0]                byte_off,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      sel_err
);

  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] result;
  logic              mapped;
  logic              in_xfer, out_xfer, acc;

  logic [DATA_W-1:0] wb_q, wb_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  wb_load_ext #(
    .DATA_W(DATA_W)
  ) u_load_ext (
    .mem_word_i(mem_word),
    .ext_mode_i(ext_mode),
    .byte_off_i(byte_off),
    .ext_data_o(ext_data)
  );

  always_comb begin
    result = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) result = src_data[k*DATA_W +: DATA_W];
    end
    if (sel == SEL_W'(NUM_SRC + OffLoad))   result = ext_data;
    if (sel == SEL_W'(NUM_SRC + OffConstA)) result = DATA_W'(ConstA);
    if (sel == SEL_W'(NUM_SRC + OffConstB)) result = DATA_W'(ConstB);
    if (sel == SEL_W'(NUM_SRC + OffConstC)) result = DATA_W'(ConstC);
    if (sel == SEL_W'(NUM_SRC + OffConstD)) result = DATA_W'(ConstD);
  end

  // Extra bit keeps the bound from wrapping when NUM_SRC+5 == 2^SEL_W.
  assign mapped   = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC + NumExtra));
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;
  assign acc      = in_xfer && mapped;
  assign err_d    = in_xfer && !mapped;

`ifdef WB_SELECT_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  always_comb begin
    wb_d         = wb_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_xfer) begin
      if (skid_valid_q) begin
        wb_d         = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end
    // acc implies the skid entry was empty, so it never collides with the refill above.
    if (acc) begin
      if (!valid_q || out_xfer) begin
        wb_d    = result;
        valid_d = 1'b1;
      end else begin
        skid_d       = result;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    wb_d    = wb_q;
    valid_d = valid_q;
    if (out_xfer) valid_d = 1'b0;
    if (acc) begin
      wb_d    = result;
      valid_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign wb_data   = wb_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_wb_select.sv
// tb_wb_select: scoreboard bench for wb_select (DATA_W=32, NUM_SRC=8, SEL_W=4).
// Expected results are pushed when a request is accepted and popped when the output is taken;
// the queue depth gives the expected out_valid / in_ready. Build with +define+WB_SELECT_SKID_EN
// to exercise the skid variant.
module tb_wb_select;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   sel = '0;
  logic [255:0] src_data = '0;
  logic [31:0]  mem_word = '0;
  logic [2:0]   ext_mode = '0;
  logic [1:0]   byte_off = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  wb_data;
  logic         sel_err;

  int checks = 0;
  int failures = 0;

  logic [31:0] sb_q[$];
  logic [31:0] last_wb = '0;
  logic        err_exp = 1'b0;
  int          acc_count = 0;

  always #5 clk = ~clk;

  wb_select #(
    .DATA_W(32),
    .NUM_SRC(8),
    .SEL_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel(sel),
    .src_data(src_data),
    .mem_word(mem_word),
    .ext_mode(ext_mode),
    .byte_off(byte_off),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wb_data(wb_data),
    .sel_err(sel_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [2:0] m,
                                            input logic [1:0] off);
    logic [31:0] sh;
    logic        hi;
    hi = off[1];
    case (m)
      3'd1: begin sh = w >> (8 * off); return {{24{sh[7]}}, sh[7:0]}; end
      3'd2: begin sh = w >> (8 * off); return {24'h0, sh[7:0]}; end
      3'd3: begin sh = w >> (16 * hi); return {{16{sh[15]}}, sh[15:0]}; end
      3'd4: begin sh = w >> (16 * hi); return {16'h0, sh[15:0]}; end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_res(input logic [3:0] s);
    case (s)
      4'd8:  return model_ext(mem_word, ext_mode, byte_off);
      4'd9:  return 32'd227;
      4'd10: return 32'd1;
      4'd11: return 32'd2;
      4'd12: return 32'd3;
      default: return src_data[s*32 +: 32];
    endcase
  endfunction

  function automatic logic model_ready();
`ifdef WB_SELECT_SKID_EN
    return sb_q.size() < 2;
`else
    return (sb_q.size() == 0) || out_ready;
`endif
  endfunction

  // Monitor: compare outputs mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (reset_n) begin
      logic exp_valid, exp_rdy, take, accept;
      exp_valid = sb_q.size() > 0;
      exp_rdy   = model_ready();
      check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
      check_eq("wb_data", wb_data, exp_valid ? sb_q[0] : last_wb);
      check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_eq("sel_err", 32'(sel_err), 32'(err_exp));
      take   = exp_valid && out_ready;
      accept = in_valid && exp_rdy;
      err_exp = accept && (sel > 4'd12);
      if (accept) acc_count++;
      if (take) last_wb = sb_q.pop_front();
      if (accept && sel <= 4'd12) sb_q.push_back(model_res(sel));
    end
  end

  task automatic drive(input logic v, input logic [3:0] s, input logic [2:0] m,
                       input logic [1:0] o, input logic r);
    in_valid  = v;
    sel       = s;
    ext_mode  = m;
    byte_off  = o;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) src_data[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Load extension, one-cycle latency.
    mem_word = 32'h80F0_7F01;
    drive(1'b1, 4'd8, 3'd1, 2'd2, 1'b1);
    check_eq("byte_s_off2", wb_data, 32'hFFFF_FFF0);
    drive(1'b1, 4'd8, 3'd4, 2'd3, 1'b1);
    check_eq("half_u_off3", wb_data, 32'h0000_80F0);
    drive(1'b1, 4'd8, 3'd0, 2'd1, 1'b1);
    check_eq("word", wb_data, 32'h80F0_7F01);

    // Back-to-back constants.
    drive(1'b1, 4'd9, 3'd0, 2'd0, 1'b1);
    check_eq("const227", wb_data, 32'd227);
    check_eq("b2b_valid0", 32'(out_valid), 32'd1);
    drive(1'b1, 4'd12, 3'd0, 2'd0, 1'b1);
    check_eq("const3", wb_data, 32'd3);
    check_eq("b2b_valid1", 32'(out_valid), 32'd1);
    drive(1'b0, 4'd0, 3'd0, 2'd0, 1'b1);
    check_eq("take_clears_valid", 32'(out_valid), 32'd0);
    check_eq("take_keeps_data", wb_data, 32'd3);

    // Unmapped select.
    src_data[31:0] = 32'h0000_1234;
    drive(1'b1, 4'd0, 3'd0, 2'd0, 1'b1);
    check_eq("src0", wb_data, 32'h1234);
    drive(1'b1, 4'd15, 3'd0, 2'd0, 1'b1);
    check_eq("err_pulse", 32'(sel_err), 32'd1);
    check_eq("err_keep_data", wb_data, 32'h1234);
    check_eq("err_no_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 4'd0, 3'd0, 2'd0, 1'b1);
    check_eq("err_one_cycle", 32'(sel_err), 32'd0);

    // Stall for three cycles with requests pending.
    drive(1'b1, 4'd9, 3'd0, 2'd0, 1'b0);
    acc_count = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd10, 3'd0, 2'd0, 1'b0);
      check_eq("stall_data", wb_data, 32'd227);
    end
`ifdef WB_SELECT_SKID_EN
    check_eq("stall_accepts", 32'(acc_count), 32'd1);
    drive(1'b0, 4'd0, 3'd0, 2'd0, 1'b1);
    check_eq("skid_drain", wb_data, 32'd1);
    check_eq("skid_drain_valid", 32'(out_valid), 32'd1);
`else
    check_eq("stall_accepts", 32'(acc_count), 32'd0);
    check_eq("stall_not_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 4'd0, 3'd0, 2'd0, 1'b1);
    check_eq("stall_release", wb_data, 32'd227);
`endif
    drive(1'b0, 4'd0, 3'd0, 2'd0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) src_data[k*32 +: 32] = $urandom();
      mem_word = $urandom();
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
    end

    // Reset in the middle of a stall.
    drive(1'b1, 4'd9, 3'd0, 2'd0, 1'b0);
    drive(1'b1, 4'd11, 3'd0, 2'd0, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", wb_data, 32'd0);
    check_eq("rst_err", 32'(sel_err), 32'd0);
    sb_q.delete();
    last_wb = '0;
    err_exp = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 4'd11, 3'd0, 2'd0, 1'b1);
    check_eq("post_rst_const2", wb_data, 32'd2);
    drive(1'b0, 4'd0, 3'd0, 2'd0, 1'b1);
    drive(1'b0, 4'd0, 3'd0, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
